// File: rtl/ped_call_arbiter.sv
// Pedestrian call arbiter: latches crosswalk button calls and grants the single
// walk phase round-robin, with a req/ready handshake, post-walk gap and watchdog.
module ped_call_arbiter #(
    parameter int unsigned TIME_W          = 6,
    parameter int unsigned GAP_CYCLES      = 4,
    parameter int unsigned WATCHDOG_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        button,
    input  logic [TIME_W-1:0] per_time,
    input  logic              phase_ready,
    input  logic              walk_done,
    output logic              walk_req,
    output logic [1:0]        walk_sel,
    output logic [TIME_W-1:0] walk_time,
    output logic              walk_active,
    output logic [3:0]        pending,
    output logic              fault
);

    localparam int unsigned WD_W  = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVE,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_button_q;
    logic [3:0]        r_pending;
    logic [1:0]        r_rr_ptr;
    logic [1:0]        r_sel;
    logic [TIME_W-1:0] r_time;
    logic [WD_W-1:0]   r_wd;
    logic [GAP_W-1:0]  r_gap;
    logic              r_fault;

    logic [3:0]        w_rise;
    logic [3:0]        w_clr;
    logic              w_hs;
    logic              w_found;
    logic [1:0]        w_pick;
    logic              w_wd_exp;
    logic              w_serve_end;

    assign w_rise   = button & ~r_button_q;
    assign w_hs     = (r_state == S_REQ) && phase_ready;
    assign w_clr    = w_hs ? (4'b0001 << r_sel) : '0;
    assign w_wd_exp = (r_wd == WD_W'(WATCHDOG_CYCLES - 1));

    // Round-robin scan starting at r_rr_ptr; index arithmetic wraps mod 4.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!w_found && r_pending[r_rr_ptr + 2'(i)]) begin
                w_found = 1'b1;
                w_pick  = r_rr_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_serve_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_next = S_REQ;
            end
            S_REQ: begin
                if (phase_ready) w_next = S_SERVE;
            end
            S_SERVE: begin
                if (walk_done || w_wd_exp) begin
                    w_serve_end = 1'b1;
                    w_next      = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap <= GAP_W'(1)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_button_q <= '0;
            r_pending  <= '0;
        end else begin
            r_state    <= w_next;
            r_button_q <= button;
            // A new rise on the granted index at the handshake edge wins over the clear.
            r_pending  <= (r_pending & ~w_clr) | w_rise;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel  <= '0;
            r_time <= '0;
        end else if (r_state == S_IDLE && w_found) begin
            r_sel  <= w_pick;
            r_time <= (per_time == '0) ? TIME_W'(1) : per_time;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_wd     <= '0;
            r_gap    <= '0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (phase_ready) r_wd <= '0;
                end
                S_SERVE: begin
                    if (w_serve_end) begin
                        r_rr_ptr <= r_sel + 2'd1;
                        r_gap    <= GAP_W'(GAP_CYCLES);
                        if (!walk_done) r_fault <= 1'b1;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap - GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign walk_req    = (r_state == S_REQ);
    assign walk_active = (r_state == S_SERVE);
    assign walk_sel    = r_sel;
    assign walk_time   = r_time;
    assign pending     = r_pending;
    assign fault       = r_fault;

endmodule

// File: tb/tb_ped_call_arbiter.sv
// Self-checking bench for ped_call_arbiter: cycle vector table through a
// scoreboard queue, plus directed round-robin, watchdog and reset sequences.
module tb_ped_call_arbiter;

    localparam int unsigned TW  = 6;
    localparam int unsigned GAP = 4;
    localparam int unsigned WDC = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    button;
    logic [TW-1:0] per_time;
    logic          phase_ready;
    logic          walk_done;
    logic          walk_req;
    logic [1:0]    walk_sel;
    logic [TW-1:0] walk_time;
    logic          walk_active;
    logic [3:0]    pending;
    logic          fault;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          req;
        logic [1:0]    sel;
        logic [TW-1:0] tm;
        logic          act;
        logic [3:0]    pend;
        logic          flt;
    } out_t;

    typedef struct {
        logic          rst;
        logic [3:0]    btn;
        logic [TW-1:0] pt;
        logic          pr;
        logic          wd;
        out_t          exp;
    } vec_t;

    vec_t vecs[$];
    out_t sb_q[$];
    int   grant_q[$];

    ped_call_arbiter #(
        .TIME_W(TW),
        .GAP_CYCLES(GAP),
        .WATCHDOG_CYCLES(WDC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .button(button),
        .per_time(per_time),
        .phase_ready(phase_ready),
        .walk_done(walk_done),
        .walk_req(walk_req),
        .walk_sel(walk_sel),
        .walk_time(walk_time),
        .walk_active(walk_active),
        .pending(pending),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input out_t e);
        chk({tag, ".req"}, 32'(walk_req), 32'(e.req));
        chk({tag, ".sel"}, 32'(walk_sel), 32'(e.sel));
        chk({tag, ".time"}, 32'(walk_time), 32'(e.tm));
        chk({tag, ".active"}, 32'(walk_active), 32'(e.act));
        chk({tag, ".pending"}, 32'(pending), 32'(e.pend));
        chk({tag, ".fault"}, 32'(fault), 32'(e.flt));
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; button = '0; phase_ready = 1'b0; walk_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!walk_req && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("req_timeout", 32'(walk_req), 32'd1);
    endtask

    function automatic vec_t mk(input logic rst, input logic [3:0] btn, input logic [TW-1:0] pt,
                                input logic pr, input logic wd, input logic req, input logic [1:0] sel,
                                input logic [TW-1:0] tm, input logic act, input logic [3:0] pend,
                                input logic flt);
        vec_t v;
        v.rst = rst; v.btn = btn; v.pt = pt; v.pr = pr; v.wd = wd;
        v.exp.req = req; v.exp.sel = sel; v.exp.tm = tm;
        v.exp.act = act; v.exp.pend = pend; v.exp.flt = flt;
        return v;
    endfunction

    initial begin
        int n;
        out_t e;
        reset = 1'b1; button = '0; per_time = '0; phase_ready = 1'b0; walk_done = 1'b0;
        #1;

        //        rst btn    pt  pr wd   req sel tm act pend   flt
        vecs.push_back(mk(1, 4'h0, 10, 0, 0,  0, 0,  0, 0, 4'h0, 0));
        vecs.push_back(mk(1, 4'h0, 10, 0, 0,  0, 0,  0, 0, 4'h0, 0));
        vecs.push_back(mk(0, 4'h1, 10, 0, 0,  0, 0,  0, 0, 4'h1, 0));
        vecs.push_back(mk(0, 4'h1, 10, 0, 0,  1, 0, 10, 0, 4'h1, 0));
        vecs.push_back(mk(0, 4'h1, 10, 1, 0,  0, 0, 10, 1, 4'h0, 0));
        vecs.push_back(mk(0, 4'h0, 10, 0, 0,  0, 0, 10, 1, 4'h0, 0));
        vecs.push_back(mk(0, 4'h0, 10, 0, 1,  0, 0, 10, 0, 4'h0, 0));
        vecs.push_back(mk(0, 4'h0, 10, 0, 0,  0, 0, 10, 0, 4'h0, 0));
        vecs.push_back(mk(0, 4'h0, 10, 0, 0,  0, 0, 10, 0, 4'h0, 0));
        vecs.push_back(mk(0, 4'h0, 10, 0, 0,  0, 0, 10, 0, 4'h0, 0));
        vecs.push_back(mk(0, 4'h4,  0, 0, 0,  0, 0, 10, 0, 4'h4, 0));
        vecs.push_back(mk(0, 4'h4,  0, 0, 0,  1, 2,  1, 0, 4'h4, 0));
        vecs.push_back(mk(0, 4'h4,  5, 0, 0,  1, 2,  1, 0, 4'h4, 0));
        vecs.push_back(mk(0, 4'h4,  5, 1, 0,  0, 2,  1, 1, 4'h0, 0));
        vecs.push_back(mk(0, 4'h0,  5, 0, 1,  0, 2,  1, 0, 4'h0, 0));
        vecs.push_back(mk(0, 4'h8,  7, 0, 1,  0, 2,  1, 0, 4'h8, 0));
        vecs.push_back(mk(0, 4'h8,  7, 1, 0,  0, 2,  1, 0, 4'h8, 0));
        vecs.push_back(mk(0, 4'h8,  7, 0, 0,  0, 2,  1, 0, 4'h8, 0));
        vecs.push_back(mk(0, 4'h8,  7, 0, 0,  0, 2,  1, 0, 4'h8, 0));
        vecs.push_back(mk(0, 4'h8,  7, 0, 0,  1, 3,  7, 0, 4'h8, 0));
        vecs.push_back(mk(0, 4'h8,  7, 1, 0,  0, 3,  7, 1, 4'h0, 0));
        vecs.push_back(mk(0, 4'h0,  7, 0, 1,  0, 3,  7, 0, 4'h0, 0));

        foreach (vecs[i]) begin
            reset = vecs[i].rst; button = vecs[i].btn; per_time = vecs[i].pt;
            phase_ready = vecs[i].pr; walk_done = vecs[i].wd;
            sb_q.push_back(vecs[i].exp);
            tick();
            e = sb_q.pop_front();
            chk_out($sformatf("vec%0d", i), e);
        end
        phase_ready = 1'b0; walk_done = 1'b0;

        // Round robin from pending=1111, with a fresh call on 0 during grant 1.
        do_reset();
        per_time = 6'd12;
        button = 4'hF;
        tick();
        chk("rr_pending_all", 32'(pending), 32'hF);
        button = 4'h0;
        grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2);
        grant_q.push_back(3); grant_q.push_back(0);
        for (int g = 0; g < 5; g++) begin
            wait_req(n);
            // Low cycles after walk_done: the GAP cycles plus the IDLE selection cycle.
            if (g > 0) chk($sformatf("rr_gap%0d", g), 32'(n), 32'(GAP + 1));
            chk($sformatf("rr_sel%0d", g), 32'(walk_sel), 32'(grant_q.pop_front()));
            phase_ready = 1'b1;
            button = (g == 1) ? 4'h1 : 4'h0;
            tick();
            phase_ready = 1'b0;
            button = 4'h0;
            chk($sformatf("rr_active%0d", g), 32'(walk_active), 32'd1);
            walk_done = 1'b1;
            tick();
            walk_done = 1'b0;
        end
        chk("rr_pending_empty", 32'(pending), 32'h0);

        // REQ holds sel/time while per_time changes and ready stays low.
        do_reset();
        per_time = 6'd10;
        button = 4'h1;
        tick();
        button = 4'h0;
        tick();
        per_time = 6'd30;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("hold_req%0d", i), 32'(walk_req), 32'd1);
            chk($sformatf("hold_sel%0d", i), 32'(walk_sel), 32'd0);
            chk($sformatf("hold_time%0d", i), 32'(walk_time), 32'd10);
        end

        // Watchdog: no walk_done while serving.
        phase_ready = 1'b1;
        tick();
        phase_ready = 1'b0;
        n = 0;
        while (walk_active && n < 40) begin
            tick();
            n++;
        end
        chk("wd_cycles", 32'(n), 32'(WDC));
        chk("wd_fault", 32'(fault), 32'd1);
        chk("wd_active_low", 32'(walk_active), 32'd0);
        button = 4'h2;
        tick();
        button = 4'h0;
        wait_req(n);
        chk("wd_next_sel", 32'(walk_sel), 32'd1);
        chk("wd_next_time", 32'(walk_time), 32'd30);
        phase_ready = 1'b1;
        tick();
        phase_ready = 1'b0;
        walk_done = 1'b1;
        tick();
        walk_done = 1'b0;
        chk("wd_fault_sticky", 32'(fault), 32'd1);
        do_reset();
        chk("wd_fault_cleared", 32'(fault), 32'd0);

        // Rise on the granted crosswalk on the handshake edge keeps it pending.
        per_time = 6'd9;
        button = 4'h1;
        tick();
        button = 4'h0;
        tick();
        chk("same_req", 32'(walk_req), 32'd1);
        button = 4'h1;
        phase_ready = 1'b1;
        tick();
        phase_ready = 1'b0;
        chk("same_pending_kept", 32'(pending), 32'h1);
        chk("same_active", 32'(walk_active), 32'd1);
        button = 4'h0;
        walk_done = 1'b1;
        tick();
        walk_done = 1'b0;
        wait_req(n);
        chk("same_regrant_sel", 32'(walk_sel), 32'd0);
        chk("same_regrant_gap", 32'(n), 32'(GAP + 1));
        phase_ready = 1'b1;
        tick();
        phase_ready = 1'b0;
        walk_done = 1'b1;
        tick();
        walk_done = 1'b0;

        // Reset in SERVE with pending=0110, buttons held across reset.
        do_reset();
        button = 4'h1;
        tick();
        button = 4'h0;
        tick();
        phase_ready = 1'b1;
        tick();
        phase_ready = 1'b0;
        button = 4'h6;
        tick();
        chk("rst_pre_pending", 32'(pending), 32'h6);
        chk("rst_pre_active", 32'(walk_active), 32'd1);
        reset = 1'b1;
        tick();
        e.req = 1'b0; e.sel = '0; e.tm = '0; e.act = 1'b0; e.pend = '0; e.flt = 1'b0;
        sb_q.push_back(e);
        chk_out("rst_mid", sb_q.pop_front());
        reset = 1'b0;
        tick();
        chk("rst_held_pending", 32'(pending), 32'h6);
        chk("rst_held_req", 32'(walk_req), 32'd0);
        button = 4'h0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ped_call_arbiter.md
Name: ped_call_arbiter

Overview:
Latches pedestrian push-button calls from the four crosswalks and grants the intersection's single pedestrian (walk) phase to one crosswalk at a time, using round-robin order. It sits between the button inputs and the intersection controller. It requests a walk phase, holds the selected crosswalk and walk duration stable through a req/ready handshake, then waits for walk completion. A minimum vehicle gap is enforced between walk phases, and a watchdog flags a controller that never finishes.

Parameters:
TIME_W, 6, width of walk-duration field (matches intersection timing inputs)
GAP_CYCLES, 4, clk cycles of forced idle after each walk phase before the next grant
WATCHDOG_CYCLES, 255, max clk cycles in SERVE without walk_done before fault

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
button  input  4  raw crosswalk buttons, already synchronised to clk, bit i = crosswalk i
per_time  input  TIME_W  configured walk duration
phase_ready  input  1  controller can start walk phase this cycle
walk_done  input  1  one-cycle pulse, controller finished walk phase
walk_req  output  1  request walk phase for walk_sel
walk_sel  output  2  granted crosswalk index
walk_time  output  TIME_W  walk duration for current grant
walk_active  output  1  high while granted phase in progress
pending  output  4  latched, unserved calls
fault  output  1  sticky watchdog flag

Behaviour:
- Reset, sampled at clk edge, has priority over everything. After reset: state IDLE, rr_ptr=0, pending=0, button_q=0, walk_req=0, walk_sel=0, walk_time=0, walk_active=0, fault=0, counters=0.
- Reset mid-operation aborts any grant. walk_req/walk_active are low the cycle after. Calls are lost.
- Call latch:
  - rise[i] = button[i] & ~button_q[i]; button_q is registered each cycle.
  - A button held high through reset release counts as a rise on the first post-reset cycle.
  - rise[i] sets pending[i] at the same edge (visible next cycle).
  - Held buttons do not re-set pending.
- Pending clear: pending[walk_sel] clears at the handshake edge (walk_req & phase_ready). A rise for the same index on that same edge wins: pending stays 1.
- FSM: IDLE, REQ, SERVE, GAP.
  - IDLE:
    - If pending != 0, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod 4.
    - Register walk_sel. Register walk_time = per_time, with per_time=0 substituted by 1.
    - Go to REQ. walk_req is high from the next cycle.
    - Selection uses the registered pending value, so latency is button rise before edge k -> pending high after k -> walk_req high after k+1.
  - REQ:
    - walk_req=1. walk_sel and walk_time are frozen; per_time changes are ignored.
    - On phase_ready: clear pending[walk_sel], walk_req=0, walk_active=1, watchdog count=0, go to SERVE.
  - SERVE:
    - walk_active=1; watchdog increments each cycle.
    - On walk_done: walk_active=0, rr_ptr = walk_sel+1 mod 4, go to GAP with gap count = GAP_CYCLES.
    - If the watchdog reaches WATCHDOG_CYCLES first: fault=1 (sticky until reset), walk_active=0, rr_ptr advances, go to GAP.
  - GAP:
    - Outputs idle. Gap count decrements each cycle; at 0, go to IDLE.
    - GAP_CYCLES=0 means SERVE goes directly to IDLE.
    - New calls still latch during GAP.
- walk_done outside SERVE is ignored. phase_ready outside REQ is ignored.
- Exactly one grant is outstanding at a time. No crosswalk waits more than 3 other grants once pending.

Test Plan:
- Reset then button=0001 rising at edge k -> pending=0001 after k; walk_req=1, walk_sel=0, walk_time=per_time after k+1; phase_ready=1 -> pending=0000, walk_active=1 next cycle.
- pending=1111, repeated handshake+walk_done -> grant order 0,1,2,3. A new call on 0 during grant 1 is served after 3. Exactly 4 idle (GAP) cycles between walk_done and the next walk_req.
- In REQ with phase_ready held low 20 cycles, change per_time 10->30 -> walk_req stays 1; walk_sel and walk_time stay 10.
- SERVE with no walk_done, WATCHDOG_CYCLES=8 -> fault=1 after 8 cycles, walk_active=0; fault stays 1 through later grants until reset.
- Rise on the granted crosswalk coinciding with the handshake edge -> pending bit remains 1; the same crosswalk is served again after the round-robin cycle.
- Reset asserted in SERVE with pending=0110 -> next cycle all outputs 0. Button held high across reset -> pending bit set on the first post-reset cycle. per_time=0 -> walk_time=1.
